// File: rtl/ili9341_lcd_ctrl.sv
// ILI9341 8-bit 8080-style write controller: reset/init sequencing, pixel writes, cursor homing.
// Define ILI9341_INVERT_EN to send display-inversion-on (0x21) just before display-on during init.

module ili9341_lcd_ctrl #(
    parameter int unsigned RESET_LOW_CYCLES  = 160,
    parameter int unsigned RESET_WAIT_CYCLES = 80000,
    parameter int unsigned SLEEP_WAIT_CYCLES = 1920000
) (
    input  logic        clk_16MHz,
    input  logic        resetn,
    output logic        nreset,
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout,
    input  logic        reset_cursor,
    input  logic [15:0] pix_data,
    input  logic        pix_clk,
    output logic        busy
);

    typedef enum logic [2:0] {
        StRstLow, StRstWait, StInit1, StSleepWait, StInit2, StCursor, StIdle, StPixel
    } state_e;

    // Zero-cycle delays still take one clock.
    localparam logic [20:0] LOW_LAST   =
        (RESET_LOW_CYCLES == 0) ? 21'd0 : 21'(RESET_LOW_CYCLES - 1);
    localparam logic [20:0] WAIT_LAST  =
        (RESET_WAIT_CYCLES == 0) ? 21'd0 : 21'(RESET_WAIT_CYCLES - 1);
    localparam logic [20:0] SLEEP_LAST =
        (SLEEP_WAIT_CYCLES == 0) ? 21'd0 : 21'(SLEEP_WAIT_CYCLES - 1);

    localparam logic [4:0] INIT2_START  = 5'd5;
`ifdef ILI9341_INVERT_EN
    localparam logic [4:0] CURSOR_START = 5'd7;
`else
    localparam logic [4:0] CURSOR_START = 5'd6;
`endif
    localparam logic [4:0] ROM_END = CURSOR_START + 5'd11;

    // ROM entries are {dc, byte}; dc = 0 marks a command byte.
    function automatic logic [8:0] rom_entry(input logic [4:0] idx);
        logic [4:0] off;
        rom_entry = 9'h000;
        off = idx - CURSOR_START;
        if (idx < INIT2_START) begin
            case (idx)
                5'd0:    rom_entry = 9'h03A;
                5'd1:    rom_entry = 9'h155;
                5'd2:    rom_entry = 9'h036;
                5'd3:    rom_entry = 9'h148;
                default: rom_entry = 9'h011;
            endcase
        end else if (idx < CURSOR_START) begin
`ifdef ILI9341_INVERT_EN
            rom_entry = (idx == INIT2_START) ? 9'h021 : 9'h029;
`else
            rom_entry = 9'h029;
`endif
        end else begin
            case (off)
                5'd0:    rom_entry = 9'h02A;
                5'd1:    rom_entry = 9'h100;
                5'd2:    rom_entry = 9'h100;
                5'd3:    rom_entry = 9'h100;
                5'd4:    rom_entry = 9'h1EF;
                5'd5:    rom_entry = 9'h02B;
                5'd6:    rom_entry = 9'h100;
                5'd7:    rom_entry = 9'h100;
                5'd8:    rom_entry = 9'h101;
                5'd9:    rom_entry = 9'h13F;
                default: rom_entry = 9'h02C;
            endcase
        end
    endfunction

    state_e      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d, stop_idx;
    logic        phase_q, phase_d;
    logic [15:0] pix_q, pix_d;
    logic        nreset_q, nreset_d, dc_q, dc_d, wr_q, wr_d, busy_q, busy_d;
    logic [7:0]  dout_q, dout_d;
    logic [8:0]  entry, cursor_first;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        pix_d        = pix_q;
        nreset_d     = nreset_q;
        dc_d         = dc_q;
        wr_d         = wr_q;
        dout_d       = dout_q;
        entry        = rom_entry(idx_q);
        cursor_first = rom_entry(CURSOR_START);

        case (state_q)
            StInit1: stop_idx = INIT2_START;
            StPixel: stop_idx = 5'd2;
            default: stop_idx = ROM_END;
        endcase

        case (state_q)
            StRstLow: begin
                nreset_d = 1'b0;
                if (cnt_q >= LOW_LAST) begin
                    state_d  = StRstWait;
                    cnt_d    = 21'd0;
                    nreset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            StRstWait: begin
                if (cnt_q >= WAIT_LAST) begin
                    state_d = StInit1;
                    cnt_d   = 21'd0;
                    idx_d   = 5'd0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            StSleepWait: begin
                if (cnt_q >= SLEEP_LAST) begin
                    state_d = StInit2;
                    cnt_d   = 21'd0;
                    idx_d   = INIT2_START;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            StInit1, StInit2, StCursor, StPixel: begin
                // phase_q = 1 means phase A is on the bus; the next edge raises WRX.
                if (phase_q) begin
                    wr_d    = 1'b1;
                    phase_d = 1'b0;
                    idx_d   = idx_q + 5'd1;
                end else if (idx_q == stop_idx) begin
                    state_d = (state_q == StInit1) ? StSleepWait : StIdle;
                    cnt_d   = 21'd0;
                end else begin
                    wr_d    = 1'b0;
                    phase_d = 1'b1;
                    if (state_q == StPixel) begin
                        dc_d   = 1'b1;
                        dout_d = idx_q[0] ? pix_q[7:0] : pix_q[15:8];
                    end else begin
                        dc_d   = entry[8];
                        dout_d = entry[7:0];
                    end
                end
            end
            StIdle: begin
                nreset_d = 1'b1;
                wr_d     = 1'b1;
                // The first byte's phase A goes out on the sampling edge itself.
                if (reset_cursor) begin
                    state_d = StCursor;
                    idx_d   = CURSOR_START;
                    phase_d = 1'b1;
                    wr_d    = 1'b0;
                    dc_d    = cursor_first[8];
                    dout_d  = cursor_first[7:0];
                end else if (pix_clk) begin
                    state_d = StPixel;
                    pix_d   = pix_data;
                    idx_d   = 5'd0;
                    phase_d = 1'b1;
                    wr_d    = 1'b0;
                    dc_d    = 1'b1;
                    dout_d  = pix_data[15:8];
                end
            end
            default: state_d = StRstLow;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_16MHz or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StRstLow;
            cnt_q    <= 21'd0;
            idx_q    <= 5'd0;
            phase_q  <= 1'b0;
            pix_q    <= 16'h0000;
            nreset_q <= 1'b0;
            dc_q     <= 1'b0;
            wr_q     <= 1'b1;
            dout_q   <= 8'h00;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            pix_q    <= pix_d;
            nreset_q <= nreset_d;
            dc_q     <= dc_d;
            wr_q     <= wr_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
        end
    end

    assign nreset     = nreset_q;
    assign cmd_data   = dc_q;
    assign write_edge = wr_q;
    assign dout       = dout_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ili9341_lcd_ctrl.sv
// Directed bench for ili9341_lcd_ctrl with shortened delays; captures bytes on WRX rising edges.
module tb_ili9341_lcd_ctrl;

    logic        clk_16MHz = 1'b0;
    logic        resetn = 1'b0;
    logic        nreset, cmd_data, write_edge, busy;
    logic [7:0]  dout;
    logic        reset_cursor = 1'b0;
    logic        pix_clk = 1'b0;
    logic [15:0] pix_data = 16'h0000;

    int checks = 0;
    int errors = 0;

    logic [8:0] cap_q[$];
    int         low_cnt = 0;

    ili9341_lcd_ctrl #(
        .RESET_LOW_CYCLES (4),
        .RESET_WAIT_CYCLES(4),
        .SLEEP_WAIT_CYCLES(4)
    ) dut (
        .clk_16MHz   (clk_16MHz),
        .resetn      (resetn),
        .nreset      (nreset),
        .cmd_data    (cmd_data),
        .write_edge  (write_edge),
        .dout        (dout),
        .reset_cursor(reset_cursor),
        .pix_data    (pix_data),
        .pix_clk     (pix_clk),
        .busy        (busy)
    );

    always #5 clk_16MHz = ~clk_16MHz;

    always @(posedge write_edge) if (resetn) cap_q.push_back({cmd_data, dout});
    always @(negedge write_edge) if (resetn) low_cnt++;

    // Drive one request at a negedge, drop it after one clock, count busy clocks.
    task automatic do_request(input logic rc, input logic pc, input logic [15:0] d,
                              output int busy_cycles);
        @(negedge clk_16MHz);
        reset_cursor = rc;
        pix_clk      = pc;
        pix_data     = d;
        busy_cycles  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_16MHz);
            reset_cursor = 1'b0;
            pix_clk      = 1'b0;
            if (busy) busy_cycles++;
            else break;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk_16MHz);
        checks++;
        if (nreset !== 1'b0) begin
            errors++; $display("FAIL reset_nreset got %b want 0", nreset);
        end
        checks++;
        if (write_edge !== 1'b1) begin
            errors++; $display("FAIL reset_write_edge got %b want 1", write_edge);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy got %b want 1", busy);
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got %h want 00", dout);
        end
        checks++;
        if (cmd_data !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_data got %b want 0", cmd_data);
        end
    endtask

    // Releases reset (assumed low) and checks the complete init stream.
    task automatic test_init;
        logic [8:0] exp_q[$];
        logic [8:0] got;
        int base, low_clks, busy_clks;
        exp_q = '{9'h03A, 9'h155, 9'h036, 9'h148, 9'h011};
`ifdef ILI9341_INVERT_EN
        exp_q.push_back(9'h021);
`endif
        exp_q.push_back(9'h029);
        exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back(9'h100); exp_q.push_back(9'h1EF);
        exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back(9'h101); exp_q.push_back(9'h13F); exp_q.push_back(9'h02C);

        base = cap_q.size();
        @(posedge clk_16MHz);
        #2 resetn = 1'b1;
        low_clks  = 0;
        busy_clks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_16MHz);
            if (nreset === 1'b0) low_clks++;
            else break;
        end
        checks++;
        if (low_clks != 4) begin
            errors++; $display("FAIL init_nreset_low got %0d clocks want 4", low_clks);
        end
        for (int i = 0; i < 300; i++) begin
            if (busy !== 1'b1) break;
            busy_clks++;
            @(negedge clk_16MHz);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL init_busy_timeout got busy=%b after %0d clocks want 0",
                               busy, busy_clks);
        end
        checks++;
        if (cap_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL init_len got %0d bytes want %0d",
                               cap_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'h1FF;
            checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL init_byte[%0d] got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_pixel;
        int base, lows, bc;
        base = cap_q.size();
        lows = low_cnt;
        do_request(1'b0, 1'b1, 16'hF81F, bc);
        checks++;
        if (bc != 4) begin
            errors++; $display("FAIL pixel_busy got %0d clocks want 4", bc);
        end
        checks++;
        if (low_cnt - lows != 2) begin
            errors++; $display("FAIL pixel_wr_lows got %0d want 2", low_cnt - lows);
        end
        checks++;
        if (cap_q.size() - base != 2) begin
            errors++; $display("FAIL pixel_len got %0d want 2", cap_q.size() - base);
        end else begin
            checks++;
            if (cap_q[base] !== 9'h1F8) begin
                errors++; $display("FAIL pixel_hi got %h want 1f8", cap_q[base]);
            end
            checks++;
            if (cap_q[base + 1] !== 9'h11F) begin
                errors++; $display("FAIL pixel_lo got %h want 11f", cap_q[base + 1]);
            end
        end
    endtask

    // Shared by the cursor and collision scenarios; mid_pix adds a pixel pulse while busy.
    task automatic test_cursor(input logic with_pix, input logic mid_pix);
        logic [8:0] exp_q[$];
        logic [8:0] got;
        int base, lows, bc;
        exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                  9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        base = cap_q.size();
        lows = low_cnt;
        @(negedge clk_16MHz);
        reset_cursor = 1'b1;
        pix_clk      = with_pix;
        pix_data     = 16'hABCD;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_16MHz);
            reset_cursor = 1'b0;
            pix_clk      = (mid_pix && i == 5) ? 1'b1 : 1'b0;
            if (busy) bc++;
            else break;
        end
        pix_clk = 1'b0;
        repeat (10) @(negedge clk_16MHz);
        checks++;
        if (bc != 22) begin
            errors++; $display("FAIL cursor_busy got %0d clocks want 22", bc);
        end
        checks++;
        if (low_cnt - lows != 11) begin
            errors++; $display("FAIL cursor_wr_lows got %0d want 11", low_cnt - lows);
        end
        checks++;
        if (cap_q.size() - base != 11) begin
            errors++; $display("FAIL cursor_len got %0d want 11", cap_q.size() - base);
        end
        foreach (exp_q[i]) begin
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'h1FF;
            checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL cursor_byte[%0d] got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_streaming;
        logic [15:0] d;
        logic [8:0]  got_hi, got_lo;
        int base, bc;
        base = cap_q.size();
        for (int i = 0; i < 240; i++) do_request(1'b0, 1'b1, 16'h7F00 + 16'(i), bc);
        checks++;
        if (cap_q.size() - base != 480) begin
            errors++; $display("FAIL stream_len got %0d want 480", cap_q.size() - base);
        end
        for (int i = 0; i < 240; i++) begin
            d = 16'h7F00 + 16'(i);
            got_hi = (base + 2 * i < cap_q.size()) ? cap_q[base + 2 * i] : 9'h0FF;
            got_lo = (base + 2 * i + 1 < cap_q.size()) ? cap_q[base + 2 * i + 1] : 9'h0FF;
            checks++;
            if (got_hi !== {1'b1, d[15:8]} || got_lo !== {1'b1, d[7:0]}) begin
                errors++; $display("FAIL stream_pixel[%0d] got %h %h want %h %h", i,
                                   got_hi, got_lo, {1'b1, d[15:8]}, {1'b1, d[7:0]});
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk_16MHz);
        pix_clk  = 1'b1;
        pix_data = 16'h1234;
        @(negedge clk_16MHz);
        pix_clk = 1'b0;
        @(posedge clk_16MHz);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (nreset !== 1'b0) begin
            errors++; $display("FAIL async_nreset got %b want 0", nreset);
        end
        checks++;
        if (write_edge !== 1'b1) begin
            errors++; $display("FAIL async_write_edge got %b want 1", write_edge);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL async_busy got %b want 1", busy);
        end
        repeat (2) @(negedge clk_16MHz);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_pixel();
        test_cursor(1'b0, 1'b0);
        test_cursor(1'b1, 1'b0);
        test_cursor(1'b0, 1'b1);
        test_streaming();
        test_async_reset();
        test_pixel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ili9341_lcd_ctrl.md
Name: ili9341_lcd_ctrl

Overview:
- Drives an ILI9341 240x320 TFT over its 8-bit 8080-style parallel write bus (D/C, WR, D[7:0], RESX).
- After reset it runs a fixed power-up/init sequence, then accepts one RGB565 pixel per request, and on request re-homes the write window.
- Sits between a pixel-generating video block and the LCD pins; `busy` provides flow control.

Parameters:
- RESET_LOW_CYCLES, 160: clocks `nreset` is held low after reset (10 us at 16 MHz).
- RESET_WAIT_CYCLES, 80000: clocks waited after `nreset` rises, before the first command (5 ms).
- SLEEP_WAIT_CYCLES, 1920000: clocks waited after Sleep Out (0x11), before Display On (120 ms).

Ports:
- clk_16MHz  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous active-low reset
- nreset  out  1  LCD RESX pin, active low
- cmd_data  out  1  LCD D/C pin: 0 = command byte, 1 = data byte
- write_edge  out  1  LCD WRX pin; LCD latches `dout` on its rising edge
- dout  out  8  LCD D[7:0]
- reset_cursor  in  1  request: re-send window and memory-write commands (home cursor)
- pix_data  in  16  RGB565 pixel, sampled when `pix_clk` is accepted
- pix_clk  in  1  request: write one pixel
- busy  out  1  1 = requests are ignored

Behaviour:
- Reset (asynchronous, `resetn` = 0), registered outputs take:
  - `nreset` = 0, `cmd_data` = 0, `write_edge` = 1, `dout` = 0x00, `busy` = 1.
  - State = RST_LOW, delay counter = 0.
- Reset mid-operation aborts any byte or sequence; the controller restarts at RST_LOW.
- Byte transfer, 2 clocks per byte:
  - Phase A: `dout` and `cmd_data` update; `write_edge` = 0.
  - Phase B: `write_edge` = 1, which gives the latch edge. `dout`/`cmd_data` stay stable through phase B.
  - Consecutive bytes follow back-to-back.
- States:
  - RST_LOW: `nreset` = 0 for RESET_LOW_CYCLES.
  - RST_WAIT: `nreset` = 1, wait RESET_WAIT_CYCLES.
  - INIT1: send cmd 0x3A, data 0x55 (16 bpp); cmd 0x36, data 0x48; cmd 0x11.
  - SLEEP_WAIT: wait SLEEP_WAIT_CYCLES.
  - INIT2: cmd 0x29 (display on), then the CURSOR sequence.
  - IDLE.
  - PIXEL.
- CURSOR sequence, 11 bytes:
  - cmd 0x2A; data 0x00, 0x00, 0x00, 0xEF.
  - cmd 0x2B; data 0x00, 0x00, 0x01, 0x3F.
  - cmd 0x2C.
- The init byte stream is held in a small indexed ROM of {dc, byte} entries; the sequencer steps through it.
- IDLE: `busy` = 0, `write_edge` = 1, `nreset` = 1.
- Request handling (a request is sampled only in IDLE):
  - `reset_cursor` = 1: run CURSOR, then return to IDLE.
  - Else `pix_clk` = 1: latch `pix_data`, then send data `pix_data[15:8]` followed by data `pix_data[7:0]` (4 clocks), then return to IDLE.
  - `reset_cursor` has priority when both are high; the pixel is dropped.
- `busy` timing:
  - Registered; rises in the clock after a request is sampled.
  - Returns to 0 in the clock after the last byte's phase B.
  - A pixel therefore yields `busy` = 1 for exactly 4 clocks.
- Requests arriving while `busy` = 1 are ignored; nothing is queued.
- Requests are level-sampled. A caller holding `pix_clk` high for several IDLE cycles gets one pixel per IDLE sample. The expected client pulses for 1 clock and waits for `busy` = 0 with `pix_clk` = 0.
- Delay counter: 21 bits, no wrap; a zero-cycle parameter means one clock minimum.

Optional Feature:
- Macro ILI9341_INVERT_EN.
- Defined: INIT2 sends cmd 0x21 (display inversion on) immediately before cmd 0x29.
- Undefined: 0x21 is never sent.
- No other difference, including the CURSOR/pixel timing.

Test Plan:
- Reset + init, parameters overridden to 4/4/4: `nreset` = 0 for 4 clocks then 1. The captured latch-edge stream is exactly (c=command, d=data):
  - c3A d55 c36 d48 c11 c29 c2A d00 d00 d00 dEF c2B d00 d00 d01 d3F c2C
  - Plus c21 before c29 when ILI9341_INVERT_EN is defined.
  - `busy` = 1 throughout, then 0.
- Pixel: in IDLE, `pix_clk` pulsed 1 clock with `pix_data` = 0xF81F → d F8, d 1F; `busy` = 1 for exactly 4 clocks; `write_edge` low exactly twice.
- Cursor: `reset_cursor` pulse → the 11-byte CURSOR stream with correct D/C per byte; `busy` = 1 for 22 clocks.
- Collision/flow: `pix_clk` and `reset_cursor` high together → only the CURSOR stream. A `pix_clk` pulse while `busy` = 1 → no bytes.
- Streaming: client loop of 240 pixels with incrementing data → 480 data bytes in order, none lost or duplicated.
- Async reset asserted mid-pixel → outputs immediately `nreset` = 0, `write_edge` = 1, `busy` = 1; full init replays after release.
